// File: rtl/mprj_io_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : mprj_io_cfg_loader
// Brief    : Fetches per-pad config words and shifts them into the GPIO chain.
// Revision : 1.0 - initial release
// ============================================================================
module mprj_io_cfg_loader #(
  parameter int NUM_PADS = 38,
  parameter int CFG_BITS = 13,
  parameter int CLK_DIV  = 4,
  localparam int IDXW    = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                cfg_rd_en,
  output logic [IDXW-1:0]     cfg_rd_idx,
  input  logic [CFG_BITS-1:0] cfg_rd_data,
  output logic                serial_clock,
  output logic                serial_data_out,
  output logic                serial_load
);

  localparam int PHW = $clog2(CLK_DIV + 1);
  localparam int BCW = $clog2(CFG_BITS + 1);
  localparam logic [PHW-1:0]  c_PH_LAST  = PHW'(CLK_DIV - 1);
  localparam logic [BCW-1:0]  c_BIT_LAST = BCW'(CFG_BITS - 1);
  localparam logic [IDXW-1:0] c_IDX_TOP  = IDXW'(NUM_PADS - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    CAPTURE  = 3'd2,
    SHIFT_LO = 3'd3,
    SHIFT_HI = 3'd4,
    LOAD     = 3'd5,
    DONE     = 3'd6
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [IDXW-1:0]     r_idx, w_idx_nxt;
  logic [BCW-1:0]      r_bit_cnt, w_bit_cnt_nxt;
  logic [PHW-1:0]      r_phase, w_phase_nxt;
  logic [CFG_BITS-1:0] r_shreg, w_shreg_nxt;
  logic                w_ph_end;

  logic                r_busy, r_done, r_rd_en, r_sclk, r_sdo, r_sload;
  logic [IDXW-1:0]     r_rd_idx;
  logic                w_busy_nxt, w_done_nxt, w_rd_en_nxt, w_sclk_nxt, w_sdo_nxt, w_sload_nxt;
  logic [IDXW-1:0]     w_rd_idx_nxt;

  assign w_ph_end = (r_phase == c_PH_LAST);

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shreg_nxt   = r_shreg;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_idx_nxt   = c_IDX_TOP;
          w_state_nxt = FETCH;
        end
      end
      FETCH:   w_state_nxt = CAPTURE;
      CAPTURE: begin
        w_shreg_nxt   = cfg_rd_data;
        w_bit_cnt_nxt = '0;
        w_state_nxt   = SHIFT_LO;
      end
      SHIFT_LO: if (w_ph_end) w_state_nxt = SHIFT_HI;
      SHIFT_HI: begin
        if (w_ph_end) begin
          w_shreg_nxt   = r_shreg << 1;
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          if (r_bit_cnt != c_BIT_LAST) begin
            w_state_nxt = SHIFT_LO;
          end else if (r_idx != '0) begin
            w_idx_nxt   = r_idx - 1'b1;
            w_state_nxt = FETCH;
          end else begin
            w_state_nxt = LOAD;
          end
        end
      end
      LOAD:    if (w_ph_end) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase

    w_phase_nxt = (w_state_nxt != r_state) ? '0 : r_phase + 1'b1;

    // Outputs are decoded from the next state so every port comes straight from a flop
    w_busy_nxt   = (w_state_nxt == FETCH) || (w_state_nxt == CAPTURE) ||
                   (w_state_nxt == SHIFT_LO) || (w_state_nxt == SHIFT_HI) ||
                   (w_state_nxt == LOAD);
    w_done_nxt   = (w_state_nxt == DONE);
    w_rd_en_nxt  = (w_state_nxt == FETCH);
    w_rd_idx_nxt = w_rd_en_nxt ? w_idx_nxt : '0;
    w_sclk_nxt   = (w_state_nxt == SHIFT_HI);
    w_sload_nxt  = (w_state_nxt == LOAD);
    w_sdo_nxt    = ((w_state_nxt == SHIFT_LO) || (w_state_nxt == SHIFT_HI)) ?
                   w_shreg_nxt[CFG_BITS-1] : 1'b0;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_bit_cnt <= '0;
      r_phase   <= '0;
      r_shreg   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rd_en   <= 1'b0;
      r_rd_idx  <= '0;
      r_sclk    <= 1'b0;
      r_sdo     <= 1'b0;
      r_sload   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_phase   <= w_phase_nxt;
      r_shreg   <= w_shreg_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_rd_en   <= w_rd_en_nxt;
      r_rd_idx  <= w_rd_idx_nxt;
      r_sclk    <= w_sclk_nxt;
      r_sdo     <= w_sdo_nxt;
      r_sload   <= w_sload_nxt;
    end
  end

  assign busy            = r_busy;
  assign done            = r_done;
  assign cfg_rd_en       = r_rd_en;
  assign cfg_rd_idx      = r_rd_idx;
  assign serial_clock    = r_sclk;
  assign serial_data_out = r_sdo;
  assign serial_load     = r_sload;

endmodule
`default_nettype wire

// File: tb/tb_mprj_io_cfg_loader.sv
`default_nettype none
// Directed bench: a 2-pad/3-bit/div-1 instance and a default-parameter instance share clock and reset.
module tb_mprj_io_cfg_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn;
  int   tests = 0;
  int   fails = 0;

  logic        start_s, busy_s, done_s, rden_s, sclk_s, sdo_s, sload_s;
  logic [0:0]  idx_s;
  logic [2:0]  rdata_s;
  logic        start_d, busy_d, done_d, rden_d, sclk_d, sdo_d, sload_d;
  logic [5:0]  idx_d;
  logic [12:0] rdata_d;

  mprj_io_cfg_loader #(.NUM_PADS(2), .CFG_BITS(3), .CLK_DIV(1)) dut_s (
    .clock(clk), .resetn(resetn), .start(start_s), .busy(busy_s), .done(done_s),
    .cfg_rd_en(rden_s), .cfg_rd_idx(idx_s), .cfg_rd_data(rdata_s),
    .serial_clock(sclk_s), .serial_data_out(sdo_s), .serial_load(sload_s)
  );

  mprj_io_cfg_loader dut_d (
    .clock(clk), .resetn(resetn), .start(start_d), .busy(busy_d), .done(done_d),
    .cfg_rd_en(rden_d), .cfg_rd_idx(idx_d), .cfg_rd_data(rdata_d),
    .serial_clock(sclk_d), .serial_data_out(sdo_d), .serial_load(sload_d)
  );

  // Register-file models with one cycle of read latency
  always_ff @(posedge clk) rdata_s <= rden_s ? ((idx_s == 1'b1) ? 3'b101 : 3'b011) : 3'b000;
  always_ff @(posedge clk) rdata_d <= rden_d ? {7'd0, idx_d} : 13'd0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge; start is raised for the next edge, extra starts at the given cycles.
  task automatic run_small(input int cycles, input int extra0, input int extra1,
                           output int done_n, output int done_first, output int done_last,
                           output int busy_n, output int load_n, output int edges,
                           output logic [5:0] bits, output int overlap);
    logic p;
    done_n = 0; done_first = -1; done_last = -1; busy_n = 0; load_n = 0;
    edges = 0; bits = '0; overlap = 0; p = 1'b0;
    start_s = 1'b1;
    for (int k = 1; k <= cycles; k++) begin
      @(negedge clk);
      start_s = (k == extra0) || (k == extra1);
      if (busy_s) busy_n++;
      if (sload_s) load_n++;
      if (sload_s && sclk_s) overlap++;
      if (done_s) begin
        done_n++;
        if (done_first < 0) done_first = k;
        done_last = k;
      end
      if (sclk_s && !p) begin
        edges++;
        bits = {bits[4:0], sdo_s};
      end
      p = sclk_s;
    end
  endtask

  task automatic run_default(input int cycles, output int done_first, output int done_n,
                             output int busy_n, output int edges, output int rd_n,
                             output int rd_bad, output int load_n, output int load_runs,
                             output int chain_bad, output int overlap);
    logic         p, pl;
    int           exp_idx;
    logic [493:0] chain;
    done_first = -1; done_n = 0; busy_n = 0; edges = 0; rd_n = 0; rd_bad = 0;
    load_n = 0; load_runs = 0; chain_bad = 0; overlap = 0;
    p = 1'b0; pl = 1'b0; exp_idx = 37; chain = '0;
    start_d = 1'b1;
    for (int k = 1; k <= cycles; k++) begin
      @(negedge clk);
      start_d = 1'b0;
      if (rden_d) begin
        rd_n++;
        if (idx_d !== 6'(exp_idx)) rd_bad++;
        exp_idx--;
      end else if (idx_d !== 6'd0) begin
        rd_bad++;
      end
      if (sload_d) begin
        load_n++;
        if (!pl) load_runs++;
      end
      if (sload_d && sclk_d) overlap++;
      if (sdo_d && !busy_d) overlap++;
      if (busy_d) busy_n++;
      if (done_d) begin
        done_n++;
        if (done_first < 0) done_first = k;
      end
      if (sclk_d && !p) begin
        edges++;
        chain = {chain[492:0], sdo_d};
      end
      p  = sclk_d;
      pl = sload_d;
    end
    for (int k = 0; k < 38; k++)
      if (chain[k*13 +: 13] !== 13'(k)) chain_bad++;
  endtask

  initial begin
    int          dn, df, dl, bn, ln, ed, ov, rn, rb, lr, cb, pre_bad;
    logic [5:0]  bits;

    resetn  = 1'b0;
    start_s = 1'b0;
    start_d = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs_small", {busy_s, done_s, rden_s, idx_s, sclk_s, sdo_s, sload_s}, 0);
    chk("reset_outs_default", {busy_d, done_d, rden_d, idx_d, sclk_d, sdo_d, sload_d}, 0);

    // Start on the very first edge after reset release
    resetn = 1'b1;
    run_small(25, -1, -1, dn, df, dl, bn, ln, ed, bits, ov);
    chk("small_done_cycle", df, 18);
    chk("small_done_count", dn, 1);
    chk("small_busy_cycles", bn, 17);
    chk("small_load_cycles", ln, 1);
    chk("small_sclk_edges", ed, 6);
    chk("small_bitstream", bits, 6'b101011);
    chk("small_chain_pad1", bits[5:3], 3'b101);
    chk("small_chain_pad0", bits[2:0], 3'b011);
    chk("small_sclk_sload_overlap", ov, 0);

    // Starts during SHIFT_HI (cycle 4) and DONE (cycle 18) are ignored
    run_small(30, 4, 18, dn, df, dl, bn, ln, ed, bits, ov);
    chk("ignore_start_done_count", dn, 1);
    chk("ignore_start_done_cycle", df, 18);
    chk("ignore_start_busy_cycles", bn, 17);

    // Back-to-back: second start the cycle after done
    run_small(45, 19, -1, dn, df, dl, bn, ln, ed, bits, ov);
    chk("b2b_done_count", dn, 2);
    chk("b2b_first_done", df, 18);
    chk("b2b_second_done", dl, 37);
    chk("b2b_busy_cycles", bn, 34);
    chk("b2b_load_cycles", ln, 2);
    chk("b2b_sclk_edges", ed, 12);
    chk("b2b_bitstream", bits, 6'b101011);

    run_default(4040, df, dn, bn, ed, rn, rb, ln, lr, cb, ov);
    chk("dflt_done_cycle", df, 4033);
    chk("dflt_done_count", dn, 1);
    chk("dflt_busy_cycles", bn, 4032);
    chk("dflt_sclk_edges", ed, 494);
    chk("dflt_rd_pulses", rn, 38);
    chk("dflt_rd_idx_errors", rb, 0);
    chk("dflt_load_cycles", ln, 4);
    chk("dflt_load_runs", lr, 1);
    chk("dflt_chain_errors", cb, 0);
    chk("dflt_output_conflicts", ov, 0);

    // Abort during the third pad's SHIFT_LO (cycles 215..218)
    pre_bad = 0;
    start_d = 1'b1;
    for (int k = 1; k <= 216; k++) begin
      @(negedge clk);
      start_d = 1'b0;
      if (done_d || sload_d) pre_bad++;
    end
    chk("mid_pre_done_load", pre_bad, 0);
    chk("mid_state_lo", {busy_d, sclk_d, rden_d}, 3'b100);
    resetn = 1'b0;
    #1;
    chk("mid_async_reset_outs", {busy_d, done_d, rden_d, idx_d, sclk_d, sdo_d, sload_d}, 0);
    pre_bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (done_d || sload_d || busy_d) pre_bad++;
    end
    chk("mid_held_in_reset", pre_bad, 0);
    resetn = 1'b1;
    run_default(4040, df, dn, bn, ed, rn, rb, ln, lr, cb, ov);
    chk("rerun_done_cycle", df, 4033);
    chk("rerun_sclk_edges", ed, 494);
    chk("rerun_rd_idx_errors", rb, 0);
    chk("rerun_load_cycles", ln, 4);
    chk("rerun_chain_errors", cb, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
